// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transceiver: parity selection, FSM states
// and the frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Bit periods in one transmitted frame.
  function automatic int unsigned frame_bits(input int unsigned data_width,
                                             input parity_e     parity,
                                             input int unsigned stop_bits);
    return 1 + data_width + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// Host-side byte stream of the UART transceiver: TX payload handshake and RX FIFO head.
interface uart_xcvr_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  logic [DATA_WIDTH-1:0]         tx_data_i;
  logic                          tx_valid_i;
  logic                          tx_ready_o;
  logic [DATA_WIDTH-1:0]         rx_data_o;
  logic                          rx_parity_err_o;
  logic                          rx_frame_err_o;
  logic                          rx_valid_o;
  logic                          rx_ready_i;
  logic                          rx_overrun_o;
  logic [$clog2(FIFO_DEPTH):0]   rx_level_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_parity_err_o, rx_frame_err_o,
           rx_valid_o, rx_overrun_o, rx_level_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_parity_err_o, rx_frame_err_o,
           rx_valid_o, rx_overrun_o, rx_level_o
  );
endinterface

// File: rtl/uart_fifo_sync.sv
// First-word fall-through FIFO for received frames; drops pushes when full unless a
// pop happens in the same cycle, and flags each drop with a one-cycle pulse.
module uart_fifo_sync #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     overrun_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_level;
  logic             r_overrun;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign empty_o   = (r_level == '0);
  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_pop     = pop_i & ~empty_o;
  assign w_push    = push_i & (~w_full | w_pop);
  assign data_o    = empty_o ? '0 : r_mem[r_rd];
  assign level_o   = r_level;
  assign overrun_o = r_overrun;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_overrun <= push_i & w_full & ~w_pop;
      if (w_push) begin
        r_mem[r_wr] <= data_i;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART: TX and RX FSMs, rxd synchroniser, internal loopback
// mux and an RX frame FIFO carrying parity/framing flags.
module uart_xcvr_param import uart_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [15:0]         prescale_i,
  input  logic                loopback_i,
  input  logic                rxd_i,
  output logic                txd_o,
  uart_xcvr_param_if.slave    bus
);
  localparam parity_e PAR     = parity_e'(2'(PARITY));
  localparam bit      HAS_PAR = (PAR != PAR_NONE);
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  logic [15:0] w_pre;
  assign w_pre = (prescale_i < 16'd2) ? 16'd2 : prescale_i;

  tx_state_e             r_tx_state;
  logic [17:0]           r_tx_cnt;
  logic [15:0]           r_tx_pre;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [3:0]            r_tx_bit;
  logic                  r_tx_line;
  logic                  r_tx_ready;
  logic                  r_tx_par;
  logic [17:0]           w_tx_reload;

  assign w_tx_reload    = {2'b00, r_tx_pre} - 18'd1;
  assign bus.tx_ready_o = r_tx_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_pre   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx_line  <= 1'b1;
      r_tx_ready <= 1'b0;
      r_tx_par   <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_line  <= 1'b1;
          r_tx_ready <= 1'b1;
          if (bus.tx_valid_i && r_tx_ready) begin
            r_tx_state <= TX_START;
            r_tx_ready <= 1'b0;
            r_tx_line  <= 1'b0;
            r_tx_pre   <= w_pre;
            r_tx_cnt   <= {2'b00, w_pre} - 18'd1;
            r_tx_shift <= bus.tx_data_i;
            r_tx_bit   <= '0;
            r_tx_par   <= (PAR == PAR_ODD) ? ~^bus.tx_data_i : ^bus.tx_data_i;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= TX_DATA;
            r_tx_line  <= r_tx_shift[0];
            r_tx_cnt   <= w_tx_reload;
          end else r_tx_cnt <= r_tx_cnt - 18'd1;
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= w_tx_reload;
            if (r_tx_bit == LAST_BIT) begin
              if (HAS_PAR) begin
                r_tx_state <= TX_PARITY;
                r_tx_line  <= r_tx_par;
              end else begin
                r_tx_state <= TX_STOP;
                r_tx_line  <= 1'b1;
                r_tx_cnt   <= (STOP_BITS == 2) ? {1'b0, r_tx_pre, 1'b0} - 18'd1 : w_tx_reload;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + 4'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_line  <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt - 18'd1;
        end
        TX_PARITY: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= TX_STOP;
            r_tx_line  <= 1'b1;
            r_tx_cnt   <= (STOP_BITS == 2) ? {1'b0, r_tx_pre, 1'b0} - 18'd1 : w_tx_reload;
          end else r_tx_cnt <= r_tx_cnt - 18'd1;
        end
        TX_STOP: begin
          // Ready is raised on the exit edge so the first IDLE cycle already accepts.
          if (r_tx_cnt == '0) begin
            r_tx_state <= TX_IDLE;
            r_tx_ready <= 1'b1;
          end else r_tx_cnt <= r_tx_cnt - 18'd1;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_e             r_rx_state;
  logic [15:0]           r_rx_cnt;
  logic [15:0]           r_rx_pre;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [3:0]            r_rx_bit;
  logic                  r_rx_par;
  logic                  r_rx_prev;
  logic                  r_loop_q;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  w_rx_line;
  logic                  w_push;
  logic                  w_perr;
  logic [DATA_WIDTH+1:0] w_push_data;
  logic [DATA_WIDTH+1:0] w_head;
  logic                  w_empty;

  assign w_rx_line = r_loop_q ? r_tx_line : r_sync[SYNC_STAGES-1];
  assign txd_o     = r_loop_q | r_tx_line;

  always_comb begin
    w_push      = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
    w_perr      = HAS_PAR && (r_rx_par != ((PAR == PAR_ODD) ? ~^r_rx_shift : ^r_rx_shift));
    w_push_data = {w_perr, ~w_rx_line, r_rx_shift};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync   <= '1;
      r_loop_q <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd_i};
      if (r_tx_state == TX_IDLE && r_rx_state == RX_IDLE) r_loop_q <= loopback_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_pre   <= '0;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
      r_rx_par   <= 1'b0;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_prev <= w_rx_line;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !w_rx_line) begin
            r_rx_state <= RX_START;
            r_rx_pre   <= w_pre;
            r_rx_cnt   <= (w_pre >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            r_rx_state <= w_rx_line ? RX_IDLE : RX_DATA;
            r_rx_cnt   <= r_rx_pre - 16'd1;
            r_rx_bit   <= '0;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {w_rx_line, r_rx_shift[DATA_WIDTH-1:1]};
            r_rx_cnt   <= r_rx_pre - 16'd1;
            if (r_rx_bit == LAST_BIT) r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else                      r_rx_bit   <= r_rx_bit + 4'd1;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RX_PARITY: begin
          if (r_rx_cnt == '0) begin
            r_rx_par   <= w_rx_line;
            r_rx_state <= RX_STOP;
            r_rx_cnt   <= r_rx_pre - 16'd1;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RX_STOP: begin
          if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
          else                r_rx_cnt   <= r_rx_cnt - 16'd1;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_fifo_sync #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .data_i    (w_push_data),
    .pop_i     (bus.rx_ready_i),
    .data_o    (w_head),
    .empty_o   (w_empty),
    .overrun_o (bus.rx_overrun_o),
    .level_o   (bus.rx_level_o)
  );

  assign bus.rx_valid_o      = ~w_empty;
  assign bus.rx_parity_err_o = w_head[DATA_WIDTH+1];
  assign bus.rx_frame_err_o  = w_head[DATA_WIDTH];
  assign bus.rx_data_o       = w_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Self-checking bench for uart_xcvr_param (8 data bits, even parity, 1 stop, 16-deep FIFO).
module tb_uart_xcvr_param;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'd4;
  logic        loopback = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;

  uart_xcvr_param_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_xcvr_param #(
    .DATA_WIDTH (DW),
    .PARITY     (1),
    .STOP_BITS  (1),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .prescale_i (prescale),
    .loopback_i (loopback),
    .rxd_i      (rxd),
    .txd_o      (txd),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_ovr = 0;
  int pre_eff = 4;

  always @(negedge clk) if (bus.rx_overrun_o === 1'b1) n_ovr++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    cyc(pre_eff);
  endtask

  // Drives one serial frame on rxd_i with an explicit parity and stop bit, then one idle bit.
  task automatic send_rx_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.rx_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic pop();
    bus.rx_ready_i = 1'b1;
    cyc(1);
    bus.rx_ready_i = 1'b0;
  endtask

  vec_t       vecs[7];
  logic [9:0] model_q[$];

  initial begin
    bit         ok;
    bit         saw_low;
    int         t_valid, t_ready, ovr0, exp_ovr, nfr;
    logic [7:0] d, dec;
    logic       flip, stp, b;
    logic [9:0] exp_w;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
    vecs[3] = '{8'hA7, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    cyc(3);
    check("rst_txd",      32'(txd), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready_o), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_level",    32'(bus.rx_level_o), 32'd0);
    check("rst_overrun",  32'(bus.rx_overrun_o), 32'd0);
    check("rst_rx_data",  32'(bus.rx_data_o), 32'd0);
    rst = 1'b0;
    cyc(2);
    check("post_rst_ready", 32'(bus.tx_ready_o), 32'd1);

    // Loopback self-test: frame must not reach txd_o and must land in the FIFO.
    loopback = 1'b1;
    cyc(2);
    bus.tx_data_i  = 8'hA5;
    bus.tx_valid_i = 1'b1;
    cyc(1);
    bus.tx_valid_i = 1'b0;
    check("lb_ready_drop", 32'(bus.tx_ready_o), 32'd0);
    t_valid = -1; t_ready = -1; saw_low = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (txd !== 1'b1) saw_low = 1'b1;
      if (t_valid < 0 && bus.rx_valid_o === 1'b1) t_valid = i;
      if (t_ready < 0 && bus.tx_ready_o === 1'b1) t_ready = i;
      if (t_valid >= 0 && t_ready >= 0) break;
      cyc(1);
    end
    check("lb_txd_idle",     32'(saw_low), 32'd0);
    check("lb_valid_in_46",  32'(t_valid >= 0 && t_valid <= 46), 32'd1);
    check("lb_frame_length", 32'(t_ready), 32'(frame_bits(8, PAR_EVEN, 1) * 4));
    check("lb_data",         32'(bus.rx_data_o), 32'hA5);
    check("lb_perr",         32'(bus.rx_parity_err_o), 32'd0);
    check("lb_ferr",         32'(bus.rx_frame_err_o), 32'd0);
    pop();
    check("lb_level_after_pop", 32'(bus.rx_level_o), 32'd0);
    loopback = 1'b0;
    cyc(2);

    foreach (vecs[k]) begin
      send_rx_frame(vecs[k].d, vecs[k].par, vecs[k].stop);
      wait_valid(40, ok);
      check($sformatf("vec%0d_valid", k), 32'(ok), 32'd1);
      check($sformatf("vec%0d_data", k),  32'(bus.rx_data_o), 32'(vecs[k].exp_d));
      check($sformatf("vec%0d_perr", k),  32'(bus.rx_parity_err_o), 32'(vecs[k].exp_pe));
      check($sformatf("vec%0d_ferr", k),  32'(bus.rx_frame_err_o), 32'(vecs[k].exp_fe));
      pop();
    end

    // Overflow: 17 frames with no pops, one dropped.
    ovr0 = n_ovr;
    for (int i = 0; i < 17; i++) begin
      d = 8'(i);
      send_rx_frame(d, ^d, 1'b1);
    end
    cyc(5);
    check("ovf_level",   32'(bus.rx_level_o), 32'd16);
    check("ovf_pulses",  32'(n_ovr - ovr0), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(bus.rx_data_o), 32'(i));
      pop();
    end
    check("ovf_empty", 32'(bus.rx_valid_o), 32'd0);
    pop();
    check("pop_empty_ignored", 32'(bus.rx_level_o), 32'd0);

    // Short low glitch must not produce a frame.
    prescale = 16'd8; pre_eff = 8;
    cyc(2);
    rxd = 1'b0;
    cyc(2);
    rxd = 1'b1;
    cyc(40);
    check("glitch_level", 32'(bus.rx_level_o), 32'd0);
    send_rx_frame(8'h69, 1'b0, 1'b1);
    wait_valid(40, ok);
    check("post_glitch_valid", 32'(ok), 32'd1);
    check("post_glitch_data",  32'({bus.rx_parity_err_o, bus.rx_frame_err_o, bus.rx_data_o}), 32'h069);
    pop();

    // Randomised batches against a queue model; prescale below 2 behaves as 2.
    for (int bt = 0; bt < 4; bt++) begin
      prescale = 16'($urandom_range(0, 7));
      pre_eff  = (prescale < 2) ? 2 : int'(prescale);
      cyc(2);
      nfr = $urandom_range(1, 20);
      exp_ovr = 0;
      ovr0 = n_ovr;
      model_q.delete();
      for (int f = 0; f < nfr; f++) begin
        d    = 8'($urandom);
        flip = ($urandom_range(0, 3) == 0);
        stp  = ($urandom_range(0, 3) != 0);
        send_rx_frame(d, (^d) ^ flip, stp);
        if (model_q.size() < DEPTH) model_q.push_back({flip, ~stp, d});
        else exp_ovr++;
        if ($urandom_range(0, 1) == 1) cyc($urandom_range(1, 3) * pre_eff);
      end
      cyc(5);
      check($sformatf("rnd%0d_overruns", bt), 32'(n_ovr - ovr0), 32'(exp_ovr));
      while (model_q.size() > 0) begin
        check($sformatf("rnd%0d_level", bt), 32'(bus.rx_level_o), 32'(model_q.size()));
        exp_w = model_q.pop_front();
        check($sformatf("rnd%0d_head", bt),
              32'({bus.rx_parity_err_o, bus.rx_frame_err_o, bus.rx_data_o}), 32'(exp_w));
        pop();
      end
      check($sformatf("rnd%0d_drained", bt), 32'(bus.rx_valid_o), 32'd0);
    end

    // Reset during TX data bit 3, then a clean frame decoded from txd_o.
    prescale = 16'd4; pre_eff = 4;
    cyc(2);
    bus.tx_data_i  = 8'hC3;
    bus.tx_valid_i = 1'b1;
    cyc(1);
    bus.tx_valid_i = 1'b0;
    cyc(17);
    check("tx_bit3_level", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_txd",   32'(txd), 32'd1);
    check("rst_mid_ready", 32'(bus.tx_ready_o), 32'd0);
    cyc(2);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_ready_o === 1'b1) begin ok = 1'b1; break; end
      cyc(1);
    end
    check("rst_release_ready", 32'(ok), 32'd1);
    bus.tx_data_i  = 8'h5A;
    bus.tx_valid_i = 1'b1;
    cyc(1);
    bus.tx_valid_i = 1'b0;
    cyc(2);
    check("tx_start_bit", 32'(txd), 32'd0);
    dec = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(4);
      b = txd;
      dec[i] = b;
    end
    check("tx_data_bits", 32'(dec), 32'h5A);
    cyc(4);
    check("tx_parity_bit", 32'(txd), 32'd0);
    cyc(4);
    check("tx_stop_bit", 32'(txd), 32'd1);
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
